// File: rtl/zero_flag_accum_if.sv
// Beat stream in, registered result out for zero_flag_accum.
// slave is the accumulator's view; master is the producer/consumer side.
interface zero_flag_accum_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
);
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_flag;
  logic             out_parity;
  logic             out_sign;
  logic [CNTW-1:0]  out_beats;
  logic [CNTW-1:0]  out_first_miss;

  modport slave (
    input  mode, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_flag, out_parity, out_sign, out_beats, out_first_miss
  );

  modport master (
    output mode, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_flag, out_parity, out_sign, out_beats, out_first_miss
  );
endinterface

// File: rtl/zero_flag_accum.sv
// Streams an operand in WIDTH-bit beats and accumulates all-zero/all-ones match,
// parity, sign, beat count and first-miss index into a one-entry output buffer.
module zero_flag_accum #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic clk,
  input  logic rst_n,
  zero_flag_accum_if.slave bus
);
  localparam logic [0:0]      IDLE  = 1'b0;
  localparam logic [0:0]      ACCUM = 1'b1;
  localparam logic [CNTW-1:0] SAT   = '1;
  localparam logic [CNTW-1:0] ONE   = {{(CNTW-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic            flag;
    logic            parity;
    logic            sign;
    logic [CNTW-1:0] beats;
    logic [CNTW-1:0] first_miss;
  } res_t;

  logic [0:0]      state;
  logic            mode_r, match_r, par_r;
  logic [CNTW-1:0] cnt_r, miss_r;
  logic            out_valid_q;
  res_t            res_q;

  logic            first, mode_eff, bm, bpar, accept;
  logic            n_match, n_par;
  logic [CNTW-1:0] n_cnt, n_miss;

  assign bus.in_ready = rst_n && !(out_valid_q && !bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    first    = (state == IDLE);
    mode_eff = first ? bus.mode : mode_r;
    bm       = mode_eff ? (&bus.in_data) : ~(|bus.in_data);
    bpar     = ^bus.in_data;
    n_match  = bm;
    n_par    = bpar;
    n_cnt    = ONE;
    n_miss   = bm ? SAT : '0;
    if (!first) begin
      n_match = match_r & bm;
      n_par   = par_r ^ bpar;
      n_cnt   = (cnt_r == SAT) ? SAT : cnt_r + ONE;
      // cnt_r is this beat's 0-based index, already clamped at SAT
      n_miss  = (miss_r == SAT && !bm) ? cnt_r : miss_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_r      <= 1'b0;
      match_r     <= 1'b0;
      par_r       <= 1'b0;
      cnt_r       <= '0;
      miss_r      <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      if (accept) begin
        if (first) mode_r <= bus.mode;
        match_r <= n_match;
        par_r   <= n_par;
        cnt_r   <= n_cnt;
        miss_r  <= n_miss;
        state   <= bus.in_last ? IDLE : ACCUM;
      end
      // a LAST accept reloads the buffer even while it drains
      if (accept && bus.in_last) begin
        out_valid_q <= 1'b1;
        res_q       <= '{flag: n_match, parity: n_par, sign: bus.in_data[WIDTH-1],
                         beats: n_cnt, first_miss: n_miss};
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.out_flag       = res_q.flag;
  assign bus.out_parity     = res_q.parity;
  assign bus.out_sign       = res_q.sign;
  assign bus.out_beats      = res_q.beats;
  assign bus.out_first_miss = res_q.first_miss;
endmodule

// File: doc/zero_flag_accum.md
# zero_flag_accum

Parametrised, registered successor to the ALU's combinational all-zero flag. It accepts an operand of any length as a stream of WIDTH-bit beats over a valid/ready handshake. It accumulates an all-zero or all-ones match flag, parity and sign across the beats, and tracks beat count and the index of the first mismatching beat. It sits after the ALU result register and feeds the flag/status register through a one-entry output buffer.

## Interface
- WIDTH, 8, bits per beat (≥ 2)
- CNTW, 4, width of beat counter and index outputs; saturation value SAT = 2^CNTW-1
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  reset, asynchronous and active-low
- MODE  in  1  0 = all-zero test, 1 = all-ones test; sampled only on the first beat of an operand
- IN_VALID  in  1  beat present
- IN_READY  out  1  beat accepted when IN_VALID && IN_READY at a rising edge
- IN_DATA  in  WIDTH  beat data
- IN_LAST  in  1  final beat of the operand
- OUT_VALID  out  1  result held in the output buffer
- OUT_READY  in  1  consumer takes the result when OUT_VALID && OUT_READY
- OUT_FLAG  out  1  1 if every bit of every beat matched the MODE pattern
- OUT_PARITY  out  1  XOR of all operand bits
- OUT_SIGN  out  1  IN_DATA[WIDTH-1] of the last beat
- OUT_BEATS  out  CNTW  number of beats in the operand, saturating at SAT
- OUT_FIRST_MISS  out  CNTW  0-based index of the first mismatching beat; SAT if none or if the index is ≥ SAT

## Operation
- Accumulator FSM has two states:
  - IDLE: no beat of the current operand has been accepted.
  - ACCUM: one or more beats accepted, LAST not yet seen.
- Beat match: MODE=0 means IN_DATA == 0; MODE=1 means IN_DATA == all-ones. Either test is a WIDTH-wide reduction.
- Accepted beat in IDLE:
  - Latch MODE into the mode register. Load match = beat match, parity = ^IN_DATA, count = 1, miss = (match ? SAT : 0).
  - If IN_LAST = 0, go to ACCUM.
- Accepted beat in ACCUM:
  - Use the latched mode; MODE is ignored.
  - match &= beat match; parity ^= ^IN_DATA; count = min(count+1, SAT).
  - If miss == SAT and the beat mismatches, set miss = min(count_before, SAT).
- Accepted beat with IN_LAST = 1, in either state:
  - Write the final values, including this beat, into the output buffer and set OUT_VALID = 1.
  - OUT_SIGN = IN_DATA[WIDTH-1]. Return to IDLE.
- IN_READY = RST_N && !(OUT_VALID && !OUT_READY). It is the same for last and non-last beats. The input stalls entirely while a result waits unconsumed.
- Output buffer:
  - OUT_VALID clears on OUT_READY unless a new LAST beat is accepted in the same cycle; in that case it reloads and stays 1.
  - All OUT_* fields are stable while OUT_VALID && !OUT_READY.
- Counters saturate and never wrap. OUT_FIRST_MISS == SAT with OUT_FLAG == 0 means the first miss was at index ≥ SAT.
- IN_DATA, IN_LAST and MODE are don't-care when IN_VALID = 0.

## Timing
- Reset (RST_N low, asynchronous):
  - FSM goes to IDLE and accumulators clear. Any partial operand is discarded.
  - OUT_VALID=0, OUT_FLAG=0, OUT_PARITY=0, OUT_SIGN=0, OUT_BEATS=0, OUT_FIRST_MISS=0, IN_READY=0.
  - Release is synchronous to the first CLK edge after RST_N rises. IN_READY=1 from the cycle RST_N is high.
- Latency: OUT_VALID rises on the edge that accepts the LAST beat, so the result is visible in the following cycle.
- Throughput: one beat per cycle. With OUT_READY held high, single-beat operands complete every cycle with no bubbles.
- Simultaneous events:
  - Output drain and new LAST accept in the same cycle gives back-to-back results.
  - A non-last beat accepted while the buffer drains affects only the accumulator.
- No combinational path from IN_DATA to any OUT_* port. IN_READY depends combinationally only on OUT_VALID, OUT_READY and RST_N.

## Test plan
- Single zero beat: MODE=0, IN_DATA=8'h00, IN_LAST=1 -> next cycle OUT_VALID=1, FLAG=1, PARITY=0, SIGN=0, BEATS=1, FIRST_MISS=4'hF.
- Zero-test miss: MODE=0, beats 8'h00, 8'h00, 8'h10 (last) -> FLAG=0, BEATS=3, FIRST_MISS=2, PARITY=1, SIGN=0.
- Ones-test with mode change: MODE=1 then MODE=0 on later beats, beats 8'hFF ×3 -> FLAG=1 (mode latched from beat 0), PARITY=0, SIGN=1, BEATS=3, FIRST_MISS=4'hF.
- Backpressure: OUT_READY=0 after a result is posted -> IN_READY=0, all OUT_* stable for 5 cycles. Then OUT_READY=1 with a pending single-beat 8'h01 -> OUT_VALID stays 1, fields update to FLAG=0, PARITY=1, FIRST_MISS=0.
- Saturation: MODE=0, 20 zero beats then 8'h80 (last, index 20) -> BEATS=4'hF, FLAG=0, FIRST_MISS=4'hF, SIGN=1, PARITY=1.
- Reset mid-operand: 2 beats accepted, RST_N pulsed low mid-cycle -> all outputs 0 immediately. Next operand 8'h00 (last) -> BEATS=1, FLAG=1, with no residue from the discarded beats.
